// File: rtl/sid_i2s_tx_if.sv
// rtl/sid_i2s_tx_if.sv - SID audio input and I2S output signal bundle for sid_i2s_tx
interface sid_i2s_tx_if;
  logic [47:0] audio_i;
  logic        audio_stb;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        frame_o;

  modport master (
    output audio_i, audio_stb,
    input  i2s_sck, i2s_ws, i2s_sd, frame_o
  );

  modport slave (
    input  audio_i, audio_stb,
    output i2s_sck, i2s_ws, i2s_sd, frame_o
  );
endinterface

// File: rtl/sid_i2s_tx.sv
// rtl/sid_i2s_tx.sv - Philips I2S transmitter, sample-and-hold decimation of the SID stereo stream
module sid_i2s_tx #(
  parameter int SCK_HALF = 4
) (
  input  logic        clk,
  input  logic        res,
  sid_i2s_tx_if.slave bus
);

  localparam int DW = $clog2(SCK_HALF);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCK_HALF - 1);

  logic [DW-1:0] div_cnt;
  logic          sck_q;
  logic          ws_q;
  logic          sd_q;
  logic          frame_q;
  logic [5:0]    n_q;
  logic [47:0]   hold_q;
  logic [63:0]   word_q;

  logic          div_wrap;
  logic          fall;
  logic [5:0]    n_next;
  logic [5:0]    n_lead;

  assign div_wrap = (div_cnt == DIV_MAX);
  assign fall     = div_wrap && sck_q;
  assign n_next   = n_q + 6'd1;
  // WS leads the data by one bit, so it follows the slot of n+1.
  assign n_lead   = n_q + 6'd2;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hold_q <= '0;
    end else if (bus.audio_stb) begin
      hold_q <= bus.audio_i;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b1;
      sd_q    <= 1'b0;
      frame_q <= 1'b0;
      n_q     <= 6'd63;
      word_q  <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      frame_q <= 1'b0;
      if (div_wrap) begin
        sck_q <= ~sck_q;
      end
      if (fall) begin
        n_q  <= n_next;
        ws_q <= n_lead[5];
        if (n_next == 6'd0) begin
          // Capture reads the pre-strobe hold value; the MSB bypasses word_q.
          word_q  <= {hold_q[47:24], 8'h00, hold_q[23:0], 8'h00};
          sd_q    <= hold_q[47];
          frame_q <= 1'b1;
        end else begin
          sd_q <= word_q[~n_next];
        end
      end
    end
  end

  assign bus.i2s_sck = sck_q;
  assign bus.i2s_ws  = ws_q;
  assign bus.i2s_sd  = sd_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb/tb_sid_i2s_tx.sv - Self-checking bench for sid_i2s_tx at SCK_HALF 4 and 2
module tb_sid_i2s_tx;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  sid_i2s_tx_if bus4 ();
  sid_i2s_tx_if bus2 ();

  sid_i2s_tx #(.SCK_HALF(4)) dut4 (.clk(clk), .res(res), .bus(bus4.slave));
  sid_i2s_tx #(.SCK_HALF(2)) dut2 (.clk(clk), .res(res), .bus(bus2.slave));

  int          checks = 0;
  int          errors = 0;
  int          e [2];
  int          frames_done [2];
  logic [47:0] hold_m [2];
  logic [63:0] sr [2];
  logic [63:0] last_frame [2];
  logic [63:0] sb0 [$];
  logic [63:0] sb1 [$];

  function automatic logic [63:0] fword(input logic [47:0] s);
    return {s[47:24], 8'h00, s[23:0], 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_sck4"}, 64'(bus4.i2s_sck), 64'd0);
    chk({tag, "_ws4"},  64'(bus4.i2s_ws),  64'd1);
    chk({tag, "_sd4"},  64'(bus4.i2s_sd),  64'd0);
    chk({tag, "_fo4"},  64'(bus4.frame_o), 64'd0);
    chk({tag, "_sck2"}, 64'(bus2.i2s_sck), 64'd0);
    chk({tag, "_ws2"},  64'(bus2.i2s_ws),  64'd1);
    chk({tag, "_sd2"},  64'(bus2.i2s_sd),  64'd0);
    chk({tag, "_fo2"},  64'(bus2.frame_o), 64'd0);
  endtask

  // Compares one DUT against the edge-count model, sampled on the falling clk edge.
  task automatic mon(input int d);
    int h;
    int n;
    logic sck, ws, sd, fo;
    logic [63:0] exp;
    h = (d == 0) ? 4 : 2;
    if (d == 0) begin
      sck = bus4.i2s_sck; ws = bus4.i2s_ws; sd = bus4.i2s_sd; fo = bus4.frame_o;
    end else begin
      sck = bus2.i2s_sck; ws = bus2.i2s_ws; sd = bus2.i2s_sd; fo = bus2.frame_o;
    end
    chk($sformatf("sck h=%0d e=%0d", h, e[d]), 64'(sck), 64'((e[d] / h) % 2));
    if (e[d] < 2 * h) begin
      chk($sformatf("ws_pre h=%0d e=%0d", h, e[d]), 64'(ws), 64'd1);
      chk($sformatf("sd_pre h=%0d e=%0d", h, e[d]), 64'(sd), 64'd0);
      chk($sformatf("fo_pre h=%0d e=%0d", h, e[d]), 64'(fo), 64'd0);
    end else begin
      n = (e[d] / (2 * h) - 1) % 64;
      chk($sformatf("frame_o h=%0d e=%0d", h, e[d]), 64'(fo),
          64'((e[d] % (2 * h) == 0) && (n == 0)));
      chk($sformatf("ws h=%0d n=%0d", h, n), 64'(ws), 64'(((n + 1) % 64) >= 32));
      if (e[d] % (2 * h) == h) begin
        sr[d] = {sr[d][62:0], sd};
        if (n == 63) begin
          checks++;
          if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
            errors++;
            $error("FAIL sb_empty h=%0d observed=none expected=frame", h);
          end else begin
            checks--;
            exp = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("frame h=%0d", h), sr[d], exp);
          end
          last_frame[d] = sr[d];
          frames_done[d]++;
        end
      end
    end
  endtask

  task automatic tick(input logic stb, input logic [47:0] val);
    int h;
    bus4.audio_stb = stb; bus4.audio_i = val;
    bus2.audio_stb = stb; bus2.audio_i = val;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      h = (d == 0) ? 4 : 2;
      if (res) begin
        e[d] = 0; hold_m[d] = '0; sr[d] = '0;
        if (d == 0) sb0.delete(); else sb1.delete();
      end else begin
        e[d]++;
        if (e[d] >= 2 * h && (e[d] - 2 * h) % (128 * h) == 0) begin
          if (d == 0) sb0.push_back(fword(hold_m[d])); else sb1.push_back(fword(hold_m[d]));
        end
        if (stb) hold_m[d] = val;
      end
    end
    @(negedge clk);
    bus4.audio_stb = 1'b0;
    bus2.audio_stb = 1'b0;
    mon(0);
    mon(1);
  endtask

  task automatic wait_frame(input int d);
    int start;
    int k;
    start = frames_done[d];
    k = 0;
    while (frames_done[d] == start && k < 3000) begin
      tick(1'b0, 48'h0);
      k++;
    end
    if (k >= 3000) begin
      checks++;
      errors++;
      $error("FAIL wait_frame observed=timeout expected=frame");
    end
  endtask

  initial begin
    logic [23:0] v;
    logic [47:0] sa, sb;
    int k;
    res = 1'b1;
    bus4.audio_i = '0; bus4.audio_stb = 1'b0;
    bus2.audio_i = '0; bus2.audio_stb = 1'b0;
    for (int d = 0; d < 2; d++) begin
      e[d] = 0; frames_done[d] = 0; hold_m[d] = '0; sr[d] = '0; last_frame[d] = '0;
    end
    #2;
    chk_outputs_reset("reset");
    repeat (3) tick(1'b0, 48'h0);

    // Startup and data format
    res = 1'b0;
    tick(1'b1, {24'h800001, 24'h7FFFFE});
    repeat (1100) tick(1'b0, 48'h0);
    chk("fmt_left4",  64'(last_frame[0][63:32]), 64'h80000100);
    chk("fmt_right4", 64'(last_frame[0][31:0]),  64'h7FFFFE00);
    chk("fmt_left2",  64'(last_frame[1][63:32]), 64'h80000100);
    chk("fmt_right2", 64'(last_frame[1][31:0]),  64'h7FFFFE00);

    // Decimation: strobes every 24 clk with incrementing values
    v = '0;
    for (int c = 0; c < 2100; c++) begin
      if (c % 24 == 0) begin
        v = v + 24'd1;
        tick(1'b1, {v, v ^ 24'h800000});
      end else begin
        tick(1'b0, 48'h0);
      end
    end

    // Collision of a strobe with the capture edge
    sb = {24'h123456, 24'hFEDCBA};
    sa = {24'hA5A5A5, 24'h5A5A5A};
    tick(1'b1, sb);
    k = 0;
    while (((e[0] + 1 - 8) % 512) != 0 && k < 1000) begin
      tick(1'b0, 48'h0);
      k++;
    end
    tick(1'b1, sa);
    wait_frame(0);
    chk("coll_old", last_frame[0], 64'h12345600FEDCBA00);
    wait_frame(0);
    chk("coll_new", last_frame[0], 64'hA5A5A5005A5A5A00);

    // Mid-frame reset at n=40 while SCK is high
    k = 0;
    while (!(e[0] >= 8 && ((e[0] / 8 - 1) % 64) == 40 && (e[0] % 8) == 4) && k < 1000) begin
      tick(1'b0, 48'h0);
      k++;
    end
    chk("rst_sck_high", 64'(bus4.i2s_sck), 64'd1);
    res = 1'b1;
    #1;
    chk_outputs_reset("async_rst");
    repeat (3) tick(1'b0, 48'h0);
    res = 1'b0;
    tick(1'b1, {24'h0F0F0F, 24'hF0F0F0});
    repeat (1100) tick(1'b0, 48'h0);
    chk("restart4", last_frame[0], 64'h0F0F0F00F0F0F000);
    chk("restart2", last_frame[1], 64'h0F0F0F00F0F0F000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
